// File: rtl/adder_pkg.sv
// Shared definitions for the prefix adders of the SAD datapath.
package adder_pkg;

  localparam int ADD_W      = 32;
  localparam int PFX_LEVELS = 5;

  // One propagate/generate pair. Packed as {p, g}, so bit 1 is p and bit 0 is g,
  // matching the pair layout on the PG front-end bus.
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Prefix (black-cell) operator: hi covers the more significant span.
  function automatic pg_t pfx_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: purely combinational prefix combine of two spans.
module ks_prefix_cell
  import adder_pkg::*;
(
  input  pg_t i_hi,
  input  pg_t i_lo,
  output pg_t o_pg
);

  assign o_pg = pfx_combine(i_hi, i_lo);

endmodule

// File: rtl/ks_carry_sum_32.sv
// Three-stage pipelined 32-bit Kogge-Stone carry tree with sum stage.
// Levels 1-2 are evaluated before stage 1, levels 3-5 before stage 2,
// and the sum/carry-out XOR before the output register.
module ks_carry_sum_32
  import adder_pkg::*;
#(
  parameter int TAG_W = 8
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        pg_in,
  input  logic               cin,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADD_W-1:0]   sum,
  output logic               cout,
  output logic [TAG_W-1:0]   tag_out
);

  // Flow control
  logic w_adv1, w_adv2, w_adv3;
  logic r_v1, r_v2, r_v3;

  // Stage payloads
  logic [ADD_W-1:0]   r_s1_p;
  logic               r_s1_cin;
  logic [TAG_W-1:0]   r_s1_tag;
  pg_t  [ADD_W-1:0]   r_s1_pg;

  logic [ADD_W-1:0]   r_s2_p;
  logic [ADD_W-1:0]   r_s2_g;
  logic               r_s2_cin;
  logic [TAG_W-1:0]   r_s2_tag;

  logic [ADD_W-1:0]   r_s3_sum;
  logic               r_s3_cout;
  logic [TAG_W-1:0]   r_s3_tag;

  // Input unpacking and carry-in fold into bit 0
  pg_t  [ADD_W-1:0]   w_pg_in;
  pg_t  [ADD_W-1:0]   w_pg_l0;
  logic [ADD_W-1:0]   w_p_in;
  logic [ADD_W-1:0]   w_g5;
  // P after the last level has no consumer; gathered here so it is visibly dropped.
  logic [ADD_W-1:0]   w_unused_p5;
  logic [ADD_W-1:0]   w_sum;

  assign w_pg_in = pg_in;

  genvar gi, gk;
  generate
    for (gi = 0; gi < ADD_W; gi++) begin : g_unpack
      assign w_p_in[gi] = w_pg_in[gi].p;
      if (gi == 0) begin : g_fold
        assign w_pg_l0[gi].p = w_pg_in[gi].p;
        assign w_pg_l0[gi].g = w_pg_in[gi].g | (w_pg_in[gi].p & cin);
      end else begin : g_pass
        assign w_pg_l0[gi] = w_pg_in[gi];
      end
    end

    // Prefix levels; level 3 restarts from the stage-1 register.
    for (gk = 1; gk <= PFX_LEVELS; gk++) begin : g_lvl
      localparam int SPAN = 1 << (gk - 1);
      pg_t [ADD_W-1:0] w_src;
      pg_t [ADD_W-1:0] w_pg;

      if (gk == 1) begin : g_src_in
        assign w_src = w_pg_l0;
      end else if (gk == 3) begin : g_src_reg
        assign w_src = r_s1_pg;
      end else begin : g_src_prev
        assign w_src = g_lvl[gk-1].w_pg;
      end

      for (gi = 0; gi < ADD_W; gi++) begin : g_bit
        if (gi < SPAN) begin : g_buf
          assign w_pg[gi] = w_src[gi];
        end else begin : g_cell
          ks_prefix_cell u_cell (
            .i_hi (w_src[gi]),
            .i_lo (w_src[gi-SPAN]),
            .o_pg (w_pg[gi])
          );
        end
      end
    end

    for (gi = 0; gi < ADD_W; gi++) begin : g_last
      assign w_g5[gi]        = g_lvl[PFX_LEVELS].w_pg[gi].g;
      assign w_unused_p5[gi] = g_lvl[PFX_LEVELS].w_pg[gi].p;
    end
  endgenerate

  // Carry into bit i is the group generate of bits i-1..0 (cin into bit 0).
  assign w_sum = r_s2_p ^ {r_s2_g[ADD_W-2:0], r_s2_cin};

  assign w_adv3   = ~r_v3 | out_ready;
  assign w_adv2   = ~r_v2 | w_adv3;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = w_adv1 & ~rst;

  // Stage 1: capture input operands and the level-2 prefix vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_s1_p   <= '0;
      r_s1_cin <= 1'b0;
      r_s1_tag <= '0;
      r_s1_pg  <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_p   <= w_p_in;
        r_s1_cin <= cin;
        r_s1_tag <= tag_in;
        r_s1_pg  <= g_lvl[2].w_pg;
      end
    end
  end

  // Stage 2: capture final group generates; P is no longer needed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_s2_p   <= '0;
      r_s2_g   <= '0;
      r_s2_cin <= 1'b0;
      r_s2_tag <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_p   <= r_s1_p;
        r_s2_g   <= w_g5;
        r_s2_cin <= r_s1_cin;
        r_s2_tag <= r_s1_tag;
      end
    end
  end

  // Stage 3: output register, held stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3      <= 1'b0;
      r_s3_sum  <= '0;
      r_s3_cout <= 1'b0;
      r_s3_tag  <= '0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_s3_sum  <= w_sum;
        r_s3_cout <= r_s2_g[ADD_W-1];
        r_s3_tag  <= r_s2_tag;
      end
    end
  end

  assign out_valid = r_v3;
  assign sum       = r_s3_sum;
  assign cout      = r_s3_cout;
  assign tag_out   = r_s3_tag;

endmodule

// File: tb/tb_ks_carry_sum_32.sv
// Scoreboard bench for ks_carry_sum_32: stimulus pushes expected results,
// a negedge monitor pops and compares every accepted output.
module tb_ks_carry_sum_32;

  typedef struct packed {
    logic        cout;
    logic [31:0] sum;
    logic [7:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pg_in;
  logic        cin;
  logic [7:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic [7:0]  tag_out;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_cnt  = 0;
  logic rnd_ready = 1'b0;
  res_t sb_q[$];

  ks_carry_sum_32 #(.TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pg_in     (pg_in),
    .cin       (cin),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  function automatic logic [63:0] mk_pg(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    for (int i = 0; i < 32; i++) begin
      r[2*i+1] = a[i] ^ b[i];
      r[2*i]   = a[i] & b[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Present one operation and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [7:0] tg, input logic [31:0] es, input logic ec);
    int waited = 0;
    pg_in = mk_pg(a, b);
    cin = c;
    tag_in = tg;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{cout: ec, sum: es, tag: tg});
        break;
      end
      waited++;
      if (waited > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: tag %h not accepted within 200 cycles", tg);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  // Random out_ready when enabled
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pop on every output transfer, plus stall stability
  initial begin
    logic        prev_stall = 1'b0;
    logic        prev_rst   = 1'b1;
    logic [63:0] prev_out   = '0;
    res_t        e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got sum=%h cout=%b tag=%h required no output",
                   sum, cout, tag_out);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("result_tag_%h", e.tag), {23'b0, cout, sum, tag_out}, {23'b0, e});
        end
      end
      if (prev_stall && !prev_rst && !rst)
        chk("stall_hold", {22'b0, out_valid, cout, sum, tag_out}, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = {22'b0, out_valid, cout, sum, tag_out};
      prev_rst   = rst;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Directed vectors: A, B, cin, hand-computed sum and cout
  logic [31:0] va [12];
  logic [31:0] vb [12];
  logic        vc [12];
  logic [31:0] vs [12];
  logic        vo [12];

  initial begin
    int          lat;
    int          t0;
    int          acc;
    int          sent;
    int          cyc;
    logic [31:0] a, b;
    logic        c;
    logic [32:0] m;

    va[0]  = 32'hFFFFFFFF; vb[0]  = 32'h00000001; vc[0]  = 1'b0; vs[0]  = 32'h00000000; vo[0]  = 1'b1;
    va[1]  = 32'h7FFFFFFF; vb[1]  = 32'h00000000; vc[1]  = 1'b1; vs[1]  = 32'h80000000; vo[1]  = 1'b0;
    va[2]  = 32'h00000000; vb[2]  = 32'h00000000; vc[2]  = 1'b1; vs[2]  = 32'h00000001; vo[2]  = 1'b0;
    va[3]  = 32'h00000000; vb[3]  = 32'h00000000; vc[3]  = 1'b0; vs[3]  = 32'h00000000; vo[3]  = 1'b0;
    va[4]  = 32'hFFFFFFFF; vb[4]  = 32'hFFFFFFFF; vc[4]  = 1'b1; vs[4]  = 32'hFFFFFFFF; vo[4]  = 1'b1;
    va[5]  = 32'h12345678; vb[5]  = 32'h87654321; vc[5]  = 1'b0; vs[5]  = 32'h99999999; vo[5]  = 1'b0;
    va[6]  = 32'h80000000; vb[6]  = 32'h80000000; vc[6]  = 1'b0; vs[6]  = 32'h00000000; vo[6]  = 1'b1;
    va[7]  = 32'hAAAAAAAA; vb[7]  = 32'h55555555; vc[7]  = 1'b1; vs[7]  = 32'h00000000; vo[7]  = 1'b1;
    va[8]  = 32'h0000FFFF; vb[8]  = 32'h00000001; vc[8]  = 1'b0; vs[8]  = 32'h00010000; vo[8]  = 1'b0;
    va[9]  = 32'hDEADBEEF; vb[9]  = 32'h00000001; vc[9]  = 1'b1; vs[9]  = 32'hDEADBEF1; vo[9]  = 1'b0;
    va[10] = 32'hFFFFFFFF; vb[10] = 32'h00000000; vc[10] = 1'b1; vs[10] = 32'h00000000; vo[10] = 1'b1;
    va[11] = 32'h40000000; vb[11] = 32'h40000000; vc[11] = 1'b0; vs[11] = 32'h80000000; vo[11] = 1'b0;

    rst = 1'b1; in_valid = 1'b0; pg_in = '0; cin = 1'b0; tag_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_outputs", {23'b0, cout, sum, tag_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Latency on an empty pipe with the full-ripple vector
    send(va[0], vb[0], vc[0], 8'hA0, vs[0], vo[0]);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    @(posedge clk); #1;

    // Remaining directed vectors back to back
    for (int i = 1; i < 12; i++)
      send(va[i], vb[i], vc[i], 8'hA0 + 8'(i), vs[i], vo[i]);
    drain();

    // Back-to-back stream with out_ready high: one accept per cycle
    t0 = cyc_cnt;
    for (int i = 0; i < 200; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      m = {1'b0, a} + {1'b0, b} + {32'b0, c};
      send(a, b, c, 8'(i), m[31:0], m[32]);
    end
    chk("stream_cycles", 64'(cyc_cnt - t0), 64'd200);
    drain();

    // Backpressure: only three operations fit while out_ready is low
    out_ready = 1'b0;
    acc = 0;
    a = 32'h0000_0010; b = 32'h0000_0003;
    for (int i = 0; i < 10; i++) begin
      pg_in = mk_pg(a, b); cin = 1'b0; tag_in = 8'hB0 + 8'(acc); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{cout: 1'b0, sum: a + b, tag: 8'hB0 + 8'(acc)});
        acc++;
        a = a + 32'h100;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd3);
    @(negedge clk);
    chk("bp_in_ready_full", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight: none may ever appear
    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 8'hC0, 32'h3333_3333, 1'b0);
    send(32'h4444_4444, 32'h1111_1111, 1'b1, 8'hC1, 32'h5555_5556, 1'b0);
    send(32'hF000_0000, 32'h2000_0000, 1'b0, 8'hC2, 32'h1000_0000, 1'b1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("in_ready_in_rst", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_outputs", {23'b0, cout, sum, tag_out}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 8'hC3, 32'h0000_000D, 1'b0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency_after_rst", 64'(lat), 64'd3);
    @(posedge clk); #1;
    drain();

    // Random valid/ready toggling
    rnd_ready = 1'b1;
    sent = 0; cyc = 0;
    a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
    while (sent < 300 && cyc < 5000) begin
      m = {1'b0, a} + {1'b0, b} + {32'b0, c};
      pg_in = mk_pg(a, b); cin = c; tag_in = 8'(sent);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back('{cout: m[32], sum: m[31:0], tag: 8'(sent)});
        sent++;
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("random_sent", 64'(sent), 64'd300);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
